xmaxpool_stream: RTL and testbench

- Streaming 2x2, stride-2, signed max-pool stage placed directly downstream of the multiply-accumulate/activation unit; consumes its activated outputs in raster order.
- Stores horizontal pair maxima of even rows in an internal line buffer and combines them with odd-row pair maxima.
- Emits one pooled value per 2x2 window to the next stage or the output memory port.

---
 rtl/xmaxpool_stream.sv | 107 ++++++++++
 tb/tb_xmaxpool_stream.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/xmaxpool_stream.sv
// xmaxpool_stream: streaming 2x2 stride-2 signed max-pool with even-row line buffer and bypass
module xmaxpool_stream #(
    parameter int DATA_W = 32,
    parameter int MAX_W  = 416,
    parameter int CNT_W  = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [CNT_W:0]    i_cfg_width,
    input  logic              i_cfg_bypass,
    input  logic              i_in_valid,
    input  logic [DATA_W-1:0] i_in_data,
    output logic              o_out_valid,
    output logic [DATA_W-1:0] o_out_data,
    output logic              o_busy
);
    localparam int LB_W = $clog2(MAX_W / 2);
    localparam logic [CNT_W:0] ONE = 1;
    localparam logic [CNT_W-1:0] COL_ONE = 1;

    logic [CNT_W:0]    r_width;
    logic              r_bypass;
    logic [CNT_W-1:0]  r_col;
    logic              r_phase;
    logic              r_row_odd;
    logic              r_busy;
    logic [DATA_W-1:0] r_hold;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic [DATA_W-1:0] r_line [MAX_W/2];

    logic              w_acc;
    logic              w_last;
    logic [CNT_W:0]    w_idx;
    logic [DATA_W-1:0] w_lb;
    logic [DATA_W-1:0] w_pmax;
    logic [DATA_W-1:0] w_res;

    // pixel acceptance, row-end detect and the two signed max stages
    always_comb begin
        w_acc  = r_busy && i_in_valid && !i_start && (r_width > ONE);
        w_idx  = {r_col, r_phase};
        w_last = w_idx == r_width - ONE;
        w_lb   = r_line[r_col[LB_W-1:0]];
        w_pmax = ($signed(i_in_data) > $signed(r_hold)) ? i_in_data : r_hold;
        w_res  = ($signed(w_lb) > $signed(w_pmax)) ? w_lb : w_pmax;
    end

    // control state, pair hold register and registered output strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_width     <= '0;
            r_bypass    <= 1'b0;
            r_col       <= '0;
            r_phase     <= 1'b0;
            r_row_odd   <= 1'b0;
            r_busy      <= 1'b0;
            r_hold      <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_out_valid <= 1'b0;
            if (i_start) begin
                r_width   <= i_cfg_width;
                r_bypass  <= i_cfg_bypass;
                r_col     <= '0;
                r_phase   <= 1'b0;
                r_row_odd <= 1'b0;
                r_busy    <= 1'b1;
            end else begin
                if (r_busy && !(r_width > ONE))
                    r_busy <= 1'b0;
                if (w_acc && r_bypass) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= i_in_data;
                end else if (w_acc) begin
                    if (!r_phase)
                        r_hold <= i_in_data;
                    else if (r_row_odd) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_res;
                    end
                    if (w_last) begin
                        r_col     <= '0;
                        r_phase   <= 1'b0;
                        r_row_odd <= ~r_row_odd;
                    end else begin
                        r_phase <= ~r_phase;
                        if (r_phase)
                            r_col <= r_col + COL_ONE;
                    end
                end
            end
        end
    end

    // even-row pair maxima into the line buffer (contents intentionally not reset)
    always_ff @(posedge clk) begin
        if (w_acc && !r_bypass && r_phase && !r_row_odd)
            r_line[r_col[LB_W-1:0]] <= w_pmax;
    end

    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_busy      = r_busy;
endmodule

// File: tb/tb_xmaxpool_stream.sv
// tb_xmaxpool_stream: directed self-checking bench for the streaming max-pool stage
module tb_xmaxpool_stream;
    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               i_start = 1'b0;
    logic [9:0]         i_cfg_width = '0;
    logic               i_cfg_bypass = 1'b0;
    logic               i_in_valid = 1'b0;
    logic signed [31:0] i_in_data = '0;
    logic               o_out_valid;
    logic [31:0]        o_out_data;
    logic               o_busy;
    int n_cmp = 0;
    int n_bad = 0;

    xmaxpool_stream dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_cfg_width(i_cfg_width),
        .i_cfg_bypass(i_cfg_bypass), .i_in_valid(i_in_valid), .i_in_data(i_in_data),
        .o_out_valid(o_out_valid), .o_out_data(o_out_data), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    task automatic do_start(input int w, input bit b, input bit v);
        logic [9:0] wv;
        wv = w[9:0];
        @(negedge clk);
        i_start = 1'b1; i_cfg_width = wv; i_cfg_bypass = b;
        i_in_valid = v; i_in_data = 1000;
        @(negedge clk);
        i_start = 1'b0; i_in_valid = 1'b0;
    endtask

    task automatic pix(input int d, input int gap);
        repeat (gap) @(negedge clk);
        @(negedge clk);
        i_in_valid = 1'b1; i_in_data = d;
        @(negedge clk);
        i_in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (o_out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %0b want 0", o_out_valid); end
        n_cmp++; if (o_out_data !== 32'd0) begin n_bad++; $display("FAIL reset_data: got %0d want 0", o_out_data); end
        n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %0b want 0", o_busy); end
        rst = 1'b0;
    endtask

    task automatic test_basic;
        int  p[8]  = '{1, 5, -3, 2, 4, 0, 7, -8};
        bit  ev[8] = '{0, 0, 0, 0, 0, 1, 0, 1};
        int  ed[8] = '{0, 0, 0, 0, 0, 5, 0, 7};
        do_start(4, 1'b0, 1'b0);
        n_cmp++; if (o_busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy: got %0b want 1", o_busy); end
        for (int i = 0; i < 8; i++) begin
            pix(p[i], 0);
            n_cmp++;
            if (o_out_valid !== ev[i] || (ev[i] && $signed(o_out_data) !== ed[i])) begin
                n_bad++; $display("FAIL basic_px%0d: valid=%0b data=%0d want valid=%0b data=%0d", i, o_out_valid, $signed(o_out_data), ev[i], ed[i]);
            end
        end
    endtask

    task automatic test_negative;
        int  p[4]  = '{-9, -4, -7, -5};
        bit  ev[4] = '{0, 0, 0, 1};
        do_start(2, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            pix(p[i], 0);
            n_cmp++;
            if (o_out_valid !== ev[i] || (ev[i] && $signed(o_out_data) !== -4)) begin
                n_bad++; $display("FAIL neg_px%0d: valid=%0b data=%0d want valid=%0b data=-4", i, o_out_valid, $signed(o_out_data), ev[i]);
            end
        end
    endtask

    task automatic test_odd_gaps;
        int  p[20]  = '{1, 2, 3, 4, 99, 0, 0, 0, 0, -1, -1, -2, -3, -4, 50, 10, -6, -1, -9, 7};
        bit  ev[20] = '{0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0};
        int  ed[20] = '{0, 0, 0, 0, 0, 0, 2, 0, 4, 0, 0, 0, 0, 0, 0, 0, 10, 0, -1, 0};
        do_start(5, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            pix(p[i], int'($urandom_range(0, 3)));
            n_cmp++;
            if (o_out_valid !== ev[i] || (ev[i] && $signed(o_out_data) !== ed[i])) begin
                n_bad++; $display("FAIL odd_px%0d: valid=%0b data=%0d want valid=%0b data=%0d", i, o_out_valid, $signed(o_out_data), ev[i], ed[i]);
            end
        end
    endtask

    task automatic test_abort;
        int  p[4]  = '{3, 8, 6, 1};
        bit  ev[4] = '{0, 0, 0, 1};
        int  q[3]  = '{100, 200, 300};
        do_start(4, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            pix(q[i], 0);
            n_cmp++; if (o_out_valid !== 1'b0) begin n_bad++; $display("FAIL abort_pre%0d: valid=%0b want 0", i, o_out_valid); end
        end
        do_start(2, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            pix(p[i], 0);
            n_cmp++;
            if (o_out_valid !== ev[i] || (ev[i] && $signed(o_out_data) !== 8)) begin
                n_bad++; $display("FAIL abort_px%0d: valid=%0b data=%0d want valid=%0b data=8", i, o_out_valid, $signed(o_out_data), ev[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        int d[3] = '{10, -20, 30};
        do_start(4, 1'b1, 1'b0);
        i_in_valid = 1'b1; i_in_data = d[0];
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (o_out_valid !== 1'b1 || $signed(o_out_data) !== d[i-1]) begin
                n_bad++; $display("FAIL bypass_%0d: valid=%0b data=%0d want 1/%0d", i - 1, o_out_valid, $signed(o_out_data), d[i-1]);
            end
            if (i < 3) i_in_data = d[i];
            else i_in_valid = 1'b0;
        end
        @(negedge clk);
        n_cmp++; if (o_out_valid !== 1'b0) begin n_bad++; $display("FAIL bypass_end: valid=%0b want 0", o_out_valid); end
    endtask

    task automatic test_degenerate;
        do_start(1, 1'b0, 1'b0);
        n_cmp++; if (o_busy !== 1'b1) begin n_bad++; $display("FAIL deg_busy_hi: got %0b want 1", o_busy); end
        i_in_valid = 1'b1; i_in_data = 5;
        @(negedge clk);
        i_in_valid = 1'b0;
        n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL deg_busy_lo: got %0b want 0", o_busy); end
        n_cmp++; if (o_out_valid !== 1'b0) begin n_bad++; $display("FAIL deg_valid0: got %0b want 0", o_out_valid); end
        pix(6, 0);
        n_cmp++; if (o_out_valid !== 1'b0) begin n_bad++; $display("FAIL deg_valid1: got %0b want 0", o_out_valid); end
    endtask

    task automatic test_async_reset;
        int  p[4]  = '{2, -3, -1, -6};
        bit  ev[4] = '{0, 0, 0, 1};
        do_start(2, 1'b0, 1'b0);
        pix(1, 0); pix(2, 0); pix(3, 0); pix(4, 0);
        n_cmp++; if (o_out_valid !== 1'b1 || o_out_data !== 32'd4) begin n_bad++; $display("FAIL ar_pre: valid=%0b data=%0d want 1/4", o_out_valid, $signed(o_out_data)); end
        pix(5, 0); pix(6, 0); pix(7, 0);
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (o_out_valid !== 1'b0) begin n_bad++; $display("FAIL ar_valid: got %0b want 0", o_out_valid); end
        n_cmp++; if (o_out_data !== 32'd0) begin n_bad++; $display("FAIL ar_data: got %0d want 0", o_out_data); end
        n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL ar_busy: got %0b want 0", o_busy); end
        @(negedge clk);
        rst = 1'b0;
        do_start(2, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            pix(p[i], 0);
            n_cmp++;
            if (o_out_valid !== ev[i] || (ev[i] && $signed(o_out_data) !== 2)) begin
                n_bad++; $display("FAIL ar_px%0d: valid=%0b data=%0d want valid=%0b data=2", i, o_out_valid, $signed(o_out_data), ev[i]);
            end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_negative;
        test_odd_gaps;
        test_abort;
        test_back_to_back;
        test_degenerate;
        test_async_reset;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
